// File: rtl/jk_pattern_pkg.sv
// Shared types and the J/K excitation rule for the JK pattern driver.
package jk_pattern_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, DRIVE, TAIL} state_e;

  localparam int MODE_SR = 0;
  localparam int MODE_HT = 1;

  // Returns {j,k} that moves a JK flop from exp_b to n.
  function automatic logic [1:0] jk_excite(input logic exp_b, input logic n, input int mode);
    if (mode == MODE_HT) return (n == exp_b) ? 2'b00 : 2'b11;
    return {n, ~n};
  endfunction

endpackage

// File: rtl/jk_pattern_chk.sv
// Compares flop feedback with the expected bit and keeps a saturating miss count.
module jk_pattern_chk #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             chk_en,
  input  logic             q_fb,
  input  logic             exp_bit,
  output logic [CNT_W-1:0] err_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic             miss;

  assign miss    = chk_en && (q_fb != exp_bit);
  assign err_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr)             cnt_q <= '0;
    else if (miss && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/jk_pattern_driver.sv
// Drives j/k so a downstream JK flop replays a pattern LSB first, and checks its q.
module jk_pattern_driver import jk_pattern_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int MODE  = MODE_SR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pat_valid,
  input  logic [WIDTH-1:0] pat_data,
  output logic             pat_ready,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             pass
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tgt_q, tgt_d;     // value the flop will hold after the current drive
  logic             qexp_q, qexp_d;   // value q_fb should show right now
  logic [1:0]       jk_q, jk_d;
  logic             busy_q, done_q, done_d, pass_q, pass_d;
  logic             clr, chk_en;

  assign pat_ready = (state_q == IDLE);
  assign j         = jk_q[1];
  assign k         = jk_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign chk_en    = (state_q == DRIVE) || (state_q == TAIL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      tgt_q   <= 1'b0;
      qexp_q  <= 1'b0;
      jk_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      qexp_q  <= qexp_d;
      jk_q    <= jk_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    qexp_d  = tgt_q;
    jk_d    = 2'b00;
    done_d  = 1'b0;
    pass_d  = pass_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: if (pat_valid) begin
        pat_d   = pat_data;
        idx_d   = '0;
        tgt_d   = 1'b0;
        jk_d    = 2'b01;
        pass_d  = 1'b0;
        clr     = 1'b1;
        state_d = PRIME;
      end
      PRIME: begin
        jk_d    = jk_excite(tgt_q, pat_q[0], MODE);
        tgt_d   = pat_q[0];
        pat_d   = pat_q >> 1;
        state_d = DRIVE;
      end
      DRIVE: if (idx_q == LAST) begin
        state_d = TAIL;
      end else begin
        jk_d  = jk_excite(tgt_q, pat_q[0], MODE);
        tgt_d = pat_q[0];
        pat_d = pat_q >> 1;
        idx_d = idx_q + 1'b1;
      end
      TAIL: begin
        // Fold the tail check into pass, since err_cnt only updates on this edge.
        state_d = IDLE;
        done_d  = 1'b1;
        pass_d  = (err_cnt == '0) && (q_fb == qexp_q);
      end
      default: state_d = IDLE;
    endcase
  end

  jk_pattern_chk #(.CNT_W(CNT_W)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .chk_en  (chk_en),
    .q_fb    (q_fb),
    .exp_bit (qexp_q),
    .err_cnt (err_cnt)
  );

endmodule
